// File: rtl/aca_csu16_recovery_ctrl.sv
// aca_csu16_recovery_ctrl
// Valid/ready sequencer around a 16-bit ACA-CSU approximate adder (eight 2-bit
// blocks). The speculative sum is returned one cycle after accept. Operand pairs
// whose speculative carries may be wrong are flagged. With RECOVER_EN set, a
// flagged pair is replaced by the exact sum, rippled one block per cycle.
module aca_csu16_recovery_ctrl #(
  parameter bit RECOVER_EN = 1'b1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          a,
  input  logic [15:0]          b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16:0]          sum,
  output logic                 out_err_flag,
  output logic                 out_exact,
  input  logic                 cnt_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SPEC, RECOVER, DONE} state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_a;
  logic [15:0]          r_b;
  logic [16:0]          r_sum;
  logic                 r_out_valid;
  logic                 r_err_flag;
  logic                 r_exact;
  logic                 r_carry;
  logic [2:0]           r_blk;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [15:0]          w_p;
  logic [15:0]          w_g;
  logic [7:0]           w_cin;
  logic [7:0]           w_cmid;
  logic [16:0]          w_spec_sum;
  logic                 w_flag;
  logic                 w_recover;
  logic [1:0]           w_rp;
  logic [1:0]           w_rg;
  logic                 w_rc_mid;
  logic                 w_rc_out;
  logic [1:0]           w_rsum;

  assign w_p       = r_a ^ r_b;
  assign w_g       = r_a & r_b;
  assign w_recover = w_flag & RECOVER_EN;

  // Speculative block carries, 2-bit CLA block sums and the conservative flag
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_cin      = '0;
    w_cmid     = '0;
    w_spec_sum = '0;
    w_flag     = 1'b0;
    w_cin[1]   = w_g[1] | (w_p[1] & w_g[0]);
    for (int j = 2; j < 8; j++) begin
      if (w_p[2*j-1] & w_p[2*j-2]) begin
        // Block j-1 propagates: guess from the top bit of block j-2 only.
        w_cin[j] = w_g[2*j-3];
        w_flag   = w_flag | w_p[2*j-3];
      end else begin
        w_cin[j] = w_g[2*j-1] | (w_p[2*j-1] & w_g[2*j-2]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      w_cmid[k]         = w_g[2*k] | (w_p[2*k] & w_cin[k]);
      w_spec_sum[2*k]   = w_p[2*k] ^ w_cin[k];
      w_spec_sum[2*k+1] = w_p[2*k+1] ^ w_cmid[k];
    end
    w_spec_sum[16] = w_g[15] | (w_p[15] & w_cmid[7]);
  end

  // Exact ripple through the block selected by r_blk
  assign w_rp     = w_p[{r_blk, 1'b0} +: 2];
  assign w_rg     = w_g[{r_blk, 1'b0} +: 2];
  assign w_rc_mid = w_rg[0] | (w_rp[0] & r_carry);
  assign w_rc_out = w_rg[1] | (w_rp[1] & w_rc_mid);
  assign w_rsum   = {w_rp[1] ^ w_rc_mid, w_rp[0] ^ r_carry};

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = SPEC;
      SPEC:    w_state_nxt = w_recover ? RECOVER : DONE;
      RECOVER: if (r_blk == 3'd7) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, result assembly and output handshake
  always_ff @(posedge clk) begin
    // NOTE: every datapath register is reset so an aborted transaction leaves no stale result behind.
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
      r_err_flag  <= 1'b0;
      r_exact     <= 1'b0;
      r_carry     <= 1'b0;
      r_blk       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        SPEC: begin
          if (w_recover) begin
            r_carry <= 1'b0;
            r_blk   <= '0;
          end else begin
            r_sum       <= w_spec_sum;
            r_err_flag  <= w_flag;
            r_exact     <= ~w_flag;
            r_out_valid <= 1'b1;
          end
        end
        RECOVER: begin
          r_sum[{r_blk, 1'b0} +: 2] <= w_rsum;
          r_carry                   <= w_rc_out;
          r_blk                     <= r_blk + 3'd1;
          if (r_blk == 3'd7) begin
            r_sum[16]   <= w_rc_out;
            r_err_flag  <= 1'b1;
            r_exact     <= 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Saturating count of flagged operations; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_err_cnt <= '0;
    end else if ((r_state == SPEC) && w_flag && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + CNT_ONE;
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = r_out_valid;
  assign sum          = r_sum;
  assign out_err_flag = r_err_flag;
  assign out_exact    = r_exact;
  assign err_cnt      = r_err_cnt;

endmodule
